// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA queue bytes in a FIFO,
// a framing FSM shifts them out LSB first, STATUS is readable combinationally.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mem_write,
   input  logic [31:0] data_addr,
   input  logic [31:0] write_data,
   output logic        sel,
   output logic [31:0] rd_data,
   output logic        uart_tx,
   output logic        tx_busy,
   output logic        overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

   logic [1:0]       state_q, state_d;
   logic [15:0]      baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       fifo_mem [FIFO_DEPTH];

   logic [3:0]  offset;
   logic        fifo_full, fifo_empty;
   logic        pop, push_req, push, ovf_set, ctrl_clr, baud_end;
   logic [31:0] status;
   logic        unused_wdata;

   assign offset     = data_addr[3:0];
   assign sel        = (data_addr[31:4] == BASE_ADDR[31:4]);
   assign fifo_full  = (count_q == CNT_FULL);
   assign fifo_empty = (count_q == '0);
   assign pop        = (state_q == S_IDLE) && !fifo_empty;
   assign push_req   = mem_write && sel && (offset == 4'h0);
   // A full FIFO still accepts a byte when the head leaves on the same edge.
   assign push       = push_req && (!fifo_full || pop);
   assign ovf_set    = push_req && fifo_full && !pop;
   assign ctrl_clr   = mem_write && sel && (offset == 4'h8) && write_data[3];
   assign baud_end   = (baud_q == BAUD_LAST);

   assign uart_tx      = tx_q;
   assign tx_busy      = (state_q != S_IDLE) || !fifo_empty;
   assign overflow     = ovf_q;
   assign unused_wdata = ^write_data[31:8];

   always_comb begin
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      ovf_d = ovf_q;
      if (ctrl_clr) ovf_d = 1'b0;
      if (ovf_set)  ovf_d = 1'b1;
   end

   // tx_d is the line level for the state being entered, so the pin is registered.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (pop) begin
               state_d = S_START;
               baud_d  = '0;
               bit_d   = '0;
               shift_d = fifo_mem[rd_ptr_q];
               tx_d    = 1'b0;
            end
         end
         S_START: begin
            if (baud_end) begin
               state_d = S_DATA;
               baud_d  = '0;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            if (baud_end) begin
               state_d = S_IDLE;
               baud_d  = '0;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_comb begin
      status       = '0;
      status[0]    = fifo_full;
      status[1]    = fifo_empty;
      status[2]    = tx_busy;
      status[3]    = ovf_q;
      status[14:8] = 7'(count_q);
      rd_data      = '0;
      if (sel && (offset == 4'h4)) rd_data = status;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         tx_q     <= 1'b1;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Payload storage carries no reset; emptiness is tracked by pointers and count.
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      if (push) fifo_mem[wr_ptr_q] <= write_data[7:0];
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8: decode table,
// hand-written frame sequences, and random bursts checked by a line decoder.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE  = 32'hFFFF_0000;
   localparam int          CPB   = 4;
   localparam int          DEPTH = 8;

   logic        clk;
   logic        reset_n;
   logic        mem_write;
   logic [31:0] data_addr;
   logic [31:0] write_data;
   logic        sel;
   logic [31:0] rd_data;
   logic        uart_tx;
   logic        tx_busy;
   logic        overflow;

   mmio_uart_tx #(
      .BASE_ADDR   (BASE),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .mem_write (mem_write),
      .data_addr (data_addr),
      .write_data(write_data),
      .sel       (sel),
      .rd_data   (rd_data),
      .uart_tx   (uart_tx),
      .tx_busy   (tx_busy),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   bit         mon_en = 1'b1;

   typedef struct {
      logic [31:0] addr;
      logic        exp_sel;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Caller is at a falling edge; the store is sampled on the next rising edge.
   task automatic store(input logic [31:0] a, input logic [31:0] d);
      mem_write  = 1'b1;
      data_addr  = a;
      write_data = d;
      @(negedge clk);
      mem_write  = 1'b0;
   endtask

   task automatic read_status(output logic [31:0] v);
      mem_write = 1'b0;
      data_addr = BASE + 32'h4;
      #1;
      v = rd_data;
   endtask

   task automatic wait_idle(input int maxc);
      bit done;
      done = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         if (!tx_busy) begin
            done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("idle_within_budget", 32'(done), 32'd1);
   endtask

   // Expected line level k cycles after the start bit begins.
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      int slot;
      slot = k / CPB;
      if (slot == 0) return 1'b0;
      if (slot >= 9) return 1'b1;
      return b[slot-1];
   endfunction

   // Line decoder: samples each bit mid-period and matches against the queue of sent bytes.
   initial begin : monitor
      logic [7:0] got;
      logic       st, sb;
      forever begin
         @(negedge clk);
         if (reset_n && uart_tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            st = uart_tx;
            for (int j = 0; j < 8; j++) begin
               repeat (CPB) @(negedge clk);
               got[j] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            sb = uart_tx;
            if (mon_en) begin
               chk("frame_start_bit", 32'(st), 32'd0);
               chk("frame_stop_bit", 32'(sb), 32'd1);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame: got byte 0x%02h expected no frame", got);
               end else begin
                  chk("frame_byte", 32'(got), 32'(exp_q.pop_front()));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [31:0] v;
      logic [31:0] d;
      int          len, exp_cnt, lows;

      tbl[0] = '{32'hFFFF_0000, 1'b1, 32'h0000_0000};
      tbl[1] = '{32'hFFFF_0004, 1'b1, 32'h0000_0002};
      tbl[2] = '{32'hFFFF_0008, 1'b1, 32'h0000_0000};
      tbl[3] = '{32'hFFFF_000C, 1'b1, 32'h0000_0000};
      tbl[4] = '{32'hFFFF_0005, 1'b1, 32'h0000_0000};
      tbl[5] = '{32'hFFFF_000F, 1'b1, 32'h0000_0000};
      tbl[6] = '{32'hFFFF_0010, 1'b0, 32'h0000_0000};
      tbl[7] = '{32'h0000_0004, 1'b0, 32'h0000_0000};
      tbl[8] = '{32'hFFFE_0004, 1'b0, 32'h0000_0000};

      reset_n    = 1'b0;
      mem_write  = 1'b0;
      data_addr  = BASE;
      write_data = '0;
      repeat (3) @(negedge clk);
      chk("tx_during_reset", 32'(uart_tx), 32'd1);
      reset_n = 1'b1;
      @(negedge clk);

      read_status(v);
      chk("reset_status", v, 32'h0000_0002);
      chk("reset_tx", 32'(uart_tx), 32'd1);
      chk("reset_busy", 32'(tx_busy), 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);

      for (int i = 0; i < 9; i++) begin
         data_addr = tbl[i].addr;
         #1;
         chk($sformatf("decode_sel[%0d]", i), 32'(sel), 32'(tbl[i].exp_sel));
         chk($sformatf("decode_rd[%0d]", i), rd_data, tbl[i].exp_rd);
      end
      @(negedge clk);

      // Single byte into an idle block
      store(BASE, 32'hDEAD_BEA5);
      exp_q.push_back(8'hA5);
      chk("single_tx_before_pop", 32'(uart_tx), 32'd1);
      read_status(v);
      chk("single_status_count1", v, 32'h0000_0104);
      for (int k = 0; k < 10 * CPB; k++) begin
         @(negedge clk);
         chk($sformatf("single_line[%0d]", k), 32'(uart_tx), 32'(frame_bit(8'hA5, k)));
      end
      chk("single_busy_in_stop", 32'(tx_busy), 32'd1);
      @(negedge clk);
      chk("single_busy_done", 32'(tx_busy), 32'd0);
      chk("single_tx_idle", 32'(uart_tx), 32'd1);

      // Back-to-back stores on consecutive edges
      store(BASE, 32'h0000_0055);
      read_status(v);
      chk("b2b_status_after_first", v, 32'h0000_0104);
      store(BASE, 32'h0000_00AA);
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      read_status(v);
      chk("b2b_status_after_second", v, 32'h0000_0104);
      for (int k = 0; k <= 20 * CPB; k++) begin
         if (k > 0) @(negedge clk);
         if (k < 10 * CPB)
            chk($sformatf("b2b_line[%0d]", k), 32'(uart_tx), 32'(frame_bit(8'h55, k)));
         else if (k == 10 * CPB)
            chk("b2b_gap_high", 32'(uart_tx), 32'd1);
         else
            chk($sformatf("b2b_line[%0d]", k), 32'(uart_tx),
                32'(frame_bit(8'hAA, k - 10 * CPB - 1)));
         if (k == 10 * CPB) begin
            read_status(v);
            chk("b2b_status_gap", v, 32'h0000_0104);
         end
         if (k == 10 * CPB + 1) begin
            read_status(v);
            chk("b2b_status_empty", v, 32'h0000_0006);
         end
      end
      @(negedge clk);
      chk("b2b_busy_done", 32'(tx_busy), 32'd0);

      // Overflow: ten consecutive stores, the last is dropped
      for (int i = 0; i < 10; i++) begin
         store(BASE, 32'(i));
         if (i < 9) exp_q.push_back(8'(i));
      end
      chk("ovf_flag_set", 32'(overflow), 32'd1);
      read_status(v);
      chk("ovf_status", v, 32'h0000_080D);
      store(BASE + 32'h8, 32'h0000_0007);
      chk("ovf_ctrl_no_bit3", 32'(overflow), 32'd1);
      store(BASE + 32'h8, 32'h0000_0008);
      chk("ovf_ctrl_clear", 32'(overflow), 32'd0);
      read_status(v);
      chk("ovf_status_cleared", v, 32'h0000_0805);
      @(negedge clk);
      wait_idle(10 * (10 * CPB + 1) + 50);
      chk("ovf_all_sent", 32'(exp_q.size()), 32'd0);

      // Decode: out-of-window and reserved-offset stores do nothing
      @(negedge clk);
      mem_write  = 1'b1;
      data_addr  = BASE + 32'h10;
      write_data = 32'h0000_0077;
      #1;
      chk("outside_sel", 32'(sel), 32'd0);
      chk("outside_rd", rd_data, 32'h0);
      @(negedge clk);
      mem_write = 1'b1;
      data_addr = BASE + 32'hC;
      #1;
      chk("offc_sel", 32'(sel), 32'd1);
      chk("offc_rd", rd_data, 32'h0);
      @(negedge clk);
      mem_write = 1'b0;
      repeat (3) @(negedge clk);
      read_status(v);
      chk("decode_no_push", v, 32'h0000_0002);
      chk("decode_line_idle", 32'(uart_tx), 32'd1);
      @(negedge clk);

      // Random bursts into an idle block
      for (int b = 0; b < 8; b++) begin
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) begin
            d = $urandom;
            store(BASE, d);
            exp_q.push_back(d[7:0]);
         end
         exp_cnt = (len > 1) ? len - 1 : 1;
         read_status(v);
         chk($sformatf("rand_status[%0d]", b), v, (32'(exp_cnt) << 8) | 32'h4);
         @(negedge clk);
         wait_idle(len * (10 * CPB + 1) + 20);
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      chk("rand_all_sent", 32'(exp_q.size()), 32'd0);
      chk("rand_no_overflow", 32'(overflow), 32'd0);

      // Reset in the middle of a frame with bytes queued
      mon_en = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) store(BASE, 32'h0);
      repeat (6) @(negedge clk);
      chk("mid_tx_low_before_reset", 32'(uart_tx), 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_tx_async_high", 32'(uart_tx), 32'd1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      read_status(v);
      chk("mid_status_after_reset", v, 32'h0000_0002);
      lows = 0;
      for (int c = 0; c < 150; c++) begin
         @(negedge clk);
         if (c == 60) mon_en = 1'b1;
         if (uart_tx !== 1'b1) lows++;
      end
      chk("mid_no_frames_after_reset", 32'(lows), 32'd0);
      chk("mid_busy_after_reset", 32'(tx_busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
